// File: rtl/wb_collector_if.sv
// wb_collector_if
//   Bundles the functional-unit writeback lanes, the per-port readiness
//   returned to issue, and the single registered commit port.
//
//   wb_vld/wb_data/wb_trans_id : one writeback lane per functional unit
//                                (0 = ALU, 1 = LSU, 2 = mul_div)
//   fu_rdy                     : per-port readiness back to the issue stage
//   commit_vld/data/trans_id   : registered commit toward regfile/scoreboard
//
//   master : functional units plus the commit consumer
//   slave  : the collector
interface wb_collector_if #(
  parameter int unsigned NR_PORTS  = 3,
  parameter int unsigned ADDR_BITS = 3,
  parameter int unsigned DATA_W    = 32
);
  logic [NR_PORTS-1:0]                wb_vld;
  logic [NR_PORTS-1:0][DATA_W-1:0]    wb_data;
  logic [NR_PORTS-1:0][ADDR_BITS-1:0] wb_trans_id;
  logic [NR_PORTS-1:0]                fu_rdy;
  logic                               commit_vld;
  logic [DATA_W-1:0]                  commit_data;
  logic [ADDR_BITS-1:0]               commit_trans_id;

  modport master (
    output wb_vld, wb_data, wb_trans_id,
    input  fu_rdy, commit_vld, commit_data, commit_trans_id
  );

  modport slave (
    input  wb_vld, wb_data, wb_trans_id,
    output fu_rdy, commit_vld, commit_data, commit_trans_id
  );
endinterface

// File: rtl/wb_collector.sv
// wb_collector
//   Consumer end of the functional-unit writeback path. Each non-stallable
//   writeback pulse is buffered in a per-port FIFO; FIFOs are drained
//   round-robin, at most one result per cycle, into a registered commit port.
//
//   clk_i      : core clock
//   rst_ni     : asynchronous active-low reset
//   flush_ex_i : discard every buffered result and the commit register
//   wb_if      : writeback lanes in, fu_rdy out, commit port out
//   idle_o     : all FIFOs empty and no commit in flight
//   overflow_o : sticky, a writeback was dropped at a full FIFO
module wb_collector #(
  parameter int unsigned NR_PORTS   = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_BITS  = 3,
  parameter int unsigned DATA_W     = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_ex_i,
  wb_collector_if.slave wb_if,
  output logic          idle_o,
  output logic          overflow_o
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned RR_W    = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam int unsigned ENTRY_W = DATA_W + ADDR_BITS;

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] RDY_MAX_C = CNT_W'(FIFO_DEPTH - 2);
  localparam logic [RR_W:0]    PORTS_C   = (RR_W + 1)'(NR_PORTS);

  logic [ENTRY_W-1:0] mem_q    [NR_PORTS][FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q [NR_PORTS];
  logic [PTR_W-1:0]   wr_ptr_d [NR_PORTS];
  logic [PTR_W-1:0]   rd_ptr_q [NR_PORTS];
  logic [PTR_W-1:0]   rd_ptr_d [NR_PORTS];
  logic [CNT_W-1:0]   cnt_q    [NR_PORTS];
  logic [CNT_W-1:0]   cnt_d    [NR_PORTS];

  logic [RR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 wb_vld_q, wb_vld_d;
  logic [DATA_W-1:0]    wb_data_q, wb_data_d;
  logic [ADDR_BITS-1:0] wb_id_q, wb_id_d;
  logic                 overflow_q, overflow_d;

  logic                grant_vld;
  logic [RR_W-1:0]     grant_idx;
  logic [RR_W:0]       cand;
  logic [RR_W:0]       rr_next;
  logic [ENTRY_W-1:0]  head_entry;
  logic [NR_PORTS-1:0] pop;
  logic [NR_PORTS-1:0] push_ok;
  logic [NR_PORTS-1:0] push_drop;

  // Round-robin arbiter: scan from rr_ptr upward with wraparound and take
  // the first non-empty FIFO. rr_ptr < NR_PORTS and the offset is below
  // NR_PORTS, so a single conditional subtract performs the modulo.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NR_PORTS; k++) begin
      cand = {1'b0, rr_ptr_q} + (RR_W + 1)'(k);
      if (cand >= PORTS_C) begin
        cand = cand - PORTS_C;
      end
      if (!grant_vld && (cnt_q[cand[RR_W-1:0]] != '0)) begin
        grant_vld = 1'b1;
        grant_idx = cand[RR_W-1:0];
      end
    end
  end

  // Per-FIFO bookkeeping. A push into a full FIFO is still accepted when
  // the same FIFO pops this cycle, because the head slot is freed at the
  // same edge. Flush overrides every push and pop.
  always_comb begin
    for (int i = 0; i < NR_PORTS; i++) begin
      pop[i]       = grant_vld && (grant_idx == RR_W'(i));
      push_ok[i]   = wb_if.wb_vld[i] && ((cnt_q[i] != DEPTH_C) || pop[i]);
      push_drop[i] = wb_if.wb_vld[i] && !push_ok[i];
      wr_ptr_d[i]  = wr_ptr_q[i];
      rd_ptr_d[i]  = rd_ptr_q[i];
      cnt_d[i]     = cnt_q[i];
      if (flush_ex_i) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        cnt_d[i]    = '0;
      end else begin
        if (push_ok[i]) begin
          wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
        end
        if (pop[i]) begin
          rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
        end
        case ({push_ok[i], pop[i]})
          2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
          2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
          default: cnt_d[i] = cnt_q[i];
        endcase
      end
    end
  end

  // Commit register, round-robin pointer and sticky overflow. The pointer
  // only advances on a real grant so an idle period keeps the fairness
  // position.
  always_comb begin
    head_entry = mem_q[grant_idx][rd_ptr_q[grant_idx]];
    rr_next    = {1'b0, grant_idx} + (RR_W + 1)'(1);
    if (rr_next >= PORTS_C) begin
      rr_next = '0;
    end
    wb_vld_d   = 1'b0;
    wb_data_d  = '0;
    wb_id_d    = '0;
    rr_ptr_d   = rr_ptr_q;
    overflow_d = overflow_q;
    if (!flush_ex_i) begin
      overflow_d = overflow_q | (|push_drop);
      if (grant_vld) begin
        wb_vld_d  = 1'b1;
        wb_data_d = head_entry[ENTRY_W-1:ADDR_BITS];
        wb_id_d   = head_entry[ADDR_BITS-1:0];
        rr_ptr_d  = rr_next[RR_W-1:0];
      end
    end
  end

  // FIFO storage carries no reset; validity is tracked by the counters.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NR_PORTS; i++) begin
      if (push_ok[i] && !flush_ex_i) begin
        mem_q[i][wr_ptr_q[i]] <= {wb_if.wb_data[i], wb_if.wb_trans_id[i]};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_PORTS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_ptr_q   <= '0;
      wb_vld_q   <= 1'b0;
      wb_data_q  <= '0;
      wb_id_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < NR_PORTS; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      rr_ptr_q   <= rr_ptr_d;
      wb_vld_q   <= wb_vld_d;
      wb_data_q  <= wb_data_d;
      wb_id_q    <= wb_id_d;
      overflow_q <= overflow_d;
    end
  end

  // Readiness keeps two free slots so a result already in flight cannot
  // collide with an issue decided in the same cycle.
  always_comb begin
    idle_o = !wb_vld_q;
    for (int i = 0; i < NR_PORTS; i++) begin
      wb_if.fu_rdy[i] = (cnt_q[i] <= RDY_MAX_C);
      if (cnt_q[i] != '0) begin
        idle_o = 1'b0;
      end
    end
  end

  assign wb_if.commit_vld      = wb_vld_q;
  assign wb_if.commit_data     = wb_data_q;
  assign wb_if.commit_trans_id = wb_id_q;
  assign overflow_o            = overflow_q;

endmodule
